// File: rtl/ddr_miss_handler.sv
// L2 miss handler: optional dirty-victim write-back, then block fill read from the DDR block controller.
// One DDR operation at a time, with an idle ram_en cycle between operations and a per-operation watchdog.
module ddr_miss_handler #(
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned CNT_W          = 13
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         miss_req,
  input  logic         miss_dirty,
  input  logic [29:0]  miss_addr,
  input  logic [29:0]  victim_addr,
  input  logic [255:0] victim_block,
  output logic         miss_ack,
  output logic [255:0] fill_block,
  output logic         busy,
  output logic         err,
  output logic         ram_en,
  output logic         ram_write,
  output logic [29:0]  ram_addr,
  output logic [255:0] data_to_ram,
  input  logic         ram_rdy,
  input  logic [255:0] block_out
);

  localparam int unsigned AW = 30;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WB_REQ,
    S_GAP,
    S_RD_REQ,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [AW-1:0]    r_miss_blk;
  logic [CNT_W-1:0] r_wd;
  logic [CNT_W-1:0] w_wd_inc;
  logic             w_timeout;
  logic             w_unused_lsbs;

  assign w_wd_inc  = r_wd + CNT_W'(1);
  assign w_timeout = (TIMEOUT_CYCLES != 0) && (w_wd_inc == CNT_W'(TIMEOUT_CYCLES));

  // Word offset within a block never reaches the DDR side.
  assign w_unused_lsbs = ^{miss_addr[2:0], victim_addr[2:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_miss_blk  <= '0;
      r_wd        <= '0;
      miss_ack    <= 1'b0;
      fill_block  <= '0;
      busy        <= 1'b0;
      err         <= 1'b0;
      ram_en      <= 1'b0;
      ram_write   <= 1'b0;
      ram_addr    <= '0;
      data_to_ram <= '0;
    end else begin
      miss_ack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (miss_req) begin
            r_miss_blk <= {miss_addr[29:3], 3'b000};
            r_wd       <= '0;
            busy       <= 1'b1;
            ram_en     <= 1'b1;
            if (miss_dirty) begin
              r_state     <= S_WB_REQ;
              ram_write   <= 1'b1;
              ram_addr    <= {victim_addr[29:3], 3'b000};
              data_to_ram <= victim_block;
            end else begin
              r_state   <= S_RD_REQ;
              ram_write <= 1'b0;
              ram_addr  <= {miss_addr[29:3], 3'b000};
            end
          end
        end
        S_WB_REQ: begin
          if (ram_rdy) begin
            r_state   <= S_GAP;
            ram_en    <= 1'b0;
            ram_write <= 1'b0;
          end else if (w_timeout) begin
            // Write-back never completed: abandon the fill and report.
            r_state   <= S_DONE;
            err       <= 1'b1;
            miss_ack  <= 1'b1;
            ram_en    <= 1'b0;
            ram_write <= 1'b0;
          end else begin
            r_wd <= w_wd_inc;
          end
        end
        S_GAP: begin
          r_state   <= S_RD_REQ;
          r_wd      <= '0;
          ram_en    <= 1'b1;
          ram_write <= 1'b0;
          ram_addr  <= r_miss_blk;
        end
        S_RD_REQ: begin
          if (ram_rdy) begin
            r_state    <= S_DONE;
            fill_block <= block_out;
            miss_ack   <= 1'b1;
            ram_en     <= 1'b0;
          end else if (w_timeout) begin
            r_state  <= S_DONE;
            err      <= 1'b1;
            miss_ack <= 1'b1;
            ram_en   <= 1'b0;
          end else begin
            r_wd <= w_wd_inc;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
        default: begin
          r_state   <= S_IDLE;
          busy      <= 1'b0;
          ram_en    <= 1'b0;
          ram_write <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_miss_handler.sv
// Directed bench for ddr_miss_handler: DDR responder model plus op/ack scoreboards.
module tb_ddr_miss_handler;

  localparam int unsigned TO = 16;

  typedef struct packed {
    logic         w;
    logic [29:0]  a;
    logic [255:0] d;
  } op_t;

  typedef struct packed {
    logic [255:0] f;
    logic         e;
  } ack_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         miss_req;
  logic         miss_dirty;
  logic [29:0]  miss_addr;
  logic [29:0]  victim_addr;
  logic [255:0] victim_block;
  logic         miss_ack;
  logic [255:0] fill_block;
  logic         busy;
  logic         err;
  logic         ram_en;
  logic         ram_write;
  logic [29:0]  ram_addr;
  logic [255:0] data_to_ram;
  logic         ram_rdy;
  logic [255:0] block_out;

  op_t  exp_op_q[$];
  ack_t exp_ack_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   ops_seen = 0;
  int   acks_seen = 0;
  int   rdy_delay = 0;
  bit   rdy_never = 1'b0;
  int   en_cnt = 0;
  logic [255:0] rd_data;
  op_t  mon_op;
  ack_t mon_ack;

  ddr_miss_handler #(.TIMEOUT_CYCLES(TO), .CNT_W(5)) dut (
    .clk(clk), .rst(rst),
    .miss_req(miss_req), .miss_dirty(miss_dirty), .miss_addr(miss_addr),
    .victim_addr(victim_addr), .victim_block(victim_block),
    .miss_ack(miss_ack), .fill_block(fill_block), .busy(busy), .err(err),
    .ram_en(ram_en), .ram_write(ram_write), .ram_addr(ram_addr),
    .data_to_ram(data_to_ram), .ram_rdy(ram_rdy), .block_out(block_out)
  );

  always #5 clk = ~clk;
  assign block_out = rd_data;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic exp_op(input logic w, input logic [29:0] a, input logic [255:0] d);
    op_t o;
    o.w = w; o.a = a; o.d = d;
    exp_op_q.push_back(o);
  endtask

  task automatic exp_ack(input logic [255:0] f, input logic e);
    ack_t k;
    k.f = f; k.e = e;
    exp_ack_q.push_back(k);
  endtask

  task automatic issue(input logic dirty, input logic [29:0] ma, input logic [29:0] va,
                       input logic [255:0] vd);
    @(negedge clk);
    miss_req = 1'b1; miss_dirty = dirty; miss_addr = ma; victim_addr = va; victim_block = vd;
    @(negedge clk);
    miss_req = 1'b0;
  endtask

  task automatic wait_ack(input int lim, output int cyc);
    cyc = 0;
    while (!miss_ack && cyc < lim) begin
      @(negedge clk);
      cyc++;
    end
    chk("ack_arrived", miss_ack, 1);
  endtask

  // DDR responder and scoreboard monitor share one sampling point.
  always @(negedge clk) begin
    if (miss_ack) begin
      acks_seen++;
      chk("ack_expected", exp_ack_q.size() > 0, 1);
      if (exp_ack_q.size() > 0) begin
        mon_ack = exp_ack_q.pop_front();
        chk("fill_block", fill_block, mon_ack.f);
        chk("err_at_ack", err, mon_ack.e);
      end
    end
    if (rst || !ram_en) begin
      en_cnt  = 0;
      ram_rdy = 1'b0;
    end else begin
      if (en_cnt == 0) begin
        ops_seen++;
        chk("op_expected", exp_op_q.size() > 0, 1);
        if (exp_op_q.size() > 0) begin
          mon_op = exp_op_q.pop_front();
          chk("op_write", ram_write, mon_op.w);
          chk("op_addr", ram_addr, mon_op.a);
          if (mon_op.w) chk("op_data", data_to_ram, mon_op.d);
        end
      end
      ram_rdy = !rdy_never && (en_cnt == rdy_delay);
      en_cnt++;
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "bench did not finish");
  end

  initial begin
    int cyc;
    int n;
    int a0;
    int o0;
    logic [255:0] last_fill;
    logic [255:0] vd;

    rst = 1'b1; miss_req = 1'b0; miss_dirty = 1'b0; miss_addr = '0;
    victim_addr = '0; victim_block = '0; rd_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_ram_en", ram_en, 0);
    chk("rst_ram_write", ram_write, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_data_to_ram", data_to_ram, 0);
    chk("rst_miss_ack", miss_ack, 0);
    chk("rst_fill_block", fill_block, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;

    // Clean miss, slow DDR
    rdy_delay = 10; rd_data = {32{8'hA5}}; last_fill = {32{8'hA5}};
    exp_op(1'b0, 30'h0000_1230, '0); exp_ack(last_fill, 1'b0);
    issue(1'b0, 30'h0000_1234, 30'h0, '0);
    chk("clean_ram_en", ram_en, 1);
    chk("clean_ram_write", ram_write, 0);
    chk("clean_ram_addr", ram_addr, 30'h0000_1230);
    chk("clean_busy", busy, 1);
    wait_ack(64, cyc);
    chk("clean_busy_at_ack", busy, 1);
    @(negedge clk);
    chk("clean_busy_after", busy, 0);
    chk("clean_ack_single", miss_ack, 0);

    // Dirty miss with exactly one idle cycle between write and read
    rdy_delay = 3; rd_data = {32{8'h5A}}; last_fill = {32{8'h5A}}; vd = {8{32'hDEAD_BEEF}};
    exp_op(1'b1, 30'h0000_0040, vd); exp_op(1'b0, 30'h0000_0088, '0); exp_ack(last_fill, 1'b0);
    issue(1'b1, 30'h0000_0088, 30'h0000_0047, vd);
    chk("dirty_ram_write", ram_write, 1);
    chk("dirty_ram_addr", ram_addr, 30'h0000_0040);
    chk("dirty_data", data_to_ram, vd);
    n = 0;
    while (ram_en && n < 32) begin @(negedge clk); n++; end
    n = 0;
    while (!ram_en && n < 8) begin @(negedge clk); n++; end
    chk("dirty_gap_cycles", n, 1);
    chk("dirty_rd_write", ram_write, 0);
    chk("dirty_rd_addr", ram_addr, 30'h0000_0088);
    wait_ack(64, cyc);

    // Same-address back-to-back clean misses, minimum latency
    rdy_delay = 0; rd_data = {8{32'h0123_4567}}; last_fill = {8{32'h0123_4567}};
    o0 = ops_seen;
    for (int i = 0; i < 2; i++) begin
      exp_op(1'b0, 30'h0000_0010, '0); exp_ack(last_fill, 1'b0);
      issue(1'b0, 30'h0000_0010, 30'h0, '0);
      wait_ack(16, cyc);
      chk("clean_min_latency", cyc, 1);
    end
    chk("repeat_two_reads", ops_seen - o0, 2);

    // Dirty miss minimum latency
    rd_data = {8{32'h89AB_CDEF}}; last_fill = {8{32'h89AB_CDEF}}; vd = {16{16'h1F2E}};
    exp_op(1'b1, 30'h0000_0100, vd); exp_op(1'b0, 30'h0000_0188, '0); exp_ack(last_fill, 1'b0);
    issue(1'b1, 30'h0000_018F, 30'h0000_0103, vd);
    wait_ack(16, cyc);
    chk("dirty_min_latency", cyc, 3);

    // Read timeout: exactly TO request cycles, ack with unchanged fill
    rdy_never = 1'b1;
    exp_op(1'b0, 30'h0000_0200, '0); exp_ack(last_fill, 1'b1);
    issue(1'b0, 30'h0000_0205, 30'h0, '0);
    n = 0;
    while (ram_en && n < 100) begin @(negedge clk); n++; end
    chk("timeout_req_cycles", n, TO);
    chk("timeout_ack", miss_ack, 1);
    chk("timeout_err", err, 1);

    // Write-back timeout skips the read
    vd = {4{64'hCAFE_F00D_1234_5678}};
    o0 = ops_seen;
    exp_op(1'b1, 30'h0000_0308, vd); exp_ack(last_fill, 1'b1);
    issue(1'b1, 30'h0000_0399, 30'h0000_030A, vd);
    wait_ack(64, cyc);
    repeat (6) @(negedge clk);
    chk("wb_timeout_no_read", ops_seen - o0, 1);

    // Successful miss after a timeout keeps err set
    rdy_never = 1'b0; rdy_delay = 2; rd_data = {32{8'hC3}}; last_fill = {32{8'hC3}};
    exp_op(1'b0, 30'h0000_0400, '0); exp_ack(last_fill, 1'b1);
    issue(1'b0, 30'h0000_0404, 30'h0, '0);
    wait_ack(32, cyc);
    @(negedge clk);
    chk("err_sticky", err, 1);

    // Requests while busy are dropped
    rdy_delay = 6; rd_data = {32{8'h0F}}; last_fill = {32{8'h0F}};
    a0 = acks_seen; o0 = ops_seen;
    exp_op(1'b0, 30'h0000_0500, '0); exp_ack(last_fill, 1'b1);
    issue(1'b0, 30'h0000_0503, 30'h0, '0);
    @(negedge clk);
    miss_req = 1'b1; miss_dirty = 1'b1; miss_addr = 30'h0000_0600; victim_addr = 30'h0000_0610;
    @(negedge clk);
    miss_req = 1'b0;
    @(negedge clk);
    miss_req = 1'b1; miss_dirty = 1'b0;
    @(negedge clk);
    miss_req = 1'b0;
    wait_ack(32, cyc);
    repeat (10) @(negedge clk);
    chk("busy_one_ack", acks_seen - a0, 1);
    chk("busy_one_op", ops_seen - o0, 1);

    // Reset during write-back abandons the transfer
    rdy_never = 1'b1; vd = {8{32'h7777_0001}};
    a0 = acks_seen;
    exp_op(1'b1, 30'h0000_0700, vd);
    issue(1'b1, 30'h0000_07FF, 30'h0000_0701, vd);
    repeat (2) @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_ram_en", ram_en, 0);
    chk("mid_rst_ram_write", ram_write, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_err", err, 0);
    chk("mid_rst_ack", miss_ack, 0);
    rst = 1'b0; rdy_never = 1'b0;
    repeat (8) @(negedge clk);
    chk("mid_rst_no_ack", acks_seen - a0, 0);
    chk("ops_drained", exp_op_q.size(), 0);
    chk("acks_drained", exp_ack_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ddr_miss_handler.md
Name: ddr_miss_handler

Overview:
- Sits directly upstream of the DDR block controller (ram_en/ram_write/ram_addr/data_to_ram/ram_rdy/block_out interface); downstream of the L2 cache miss path.
- Accepts a single cache-miss request, optionally writes back a dirty 256-bit victim block, then reads the 256-bit fill block and returns it with a one-cycle acknowledge.
- Guarantees a NOP cycle (ram_en low) between consecutive DDR operations, so repeated same-address or same-op requests are always re-issued.
- Includes a per-operation timeout watchdog with a sticky error flag.

Parameters:
- TIMEOUT_CYCLES, 4096, cycles to wait for ram_rdy per DDR operation; 0 disables the watchdog.
- CNT_W, 13, watchdog counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  block clock; DDR request side shares this clock.
- rst  in  1  reset: synchronous, active-high.
- miss_req  in  1  single-cycle request pulse; accepted only in IDLE.
- miss_dirty  in  1  victim block must be written back first.
- miss_addr  in  30  word address of missing data.
- victim_addr  in  30  word address of victim block.
- victim_block  in  256  victim data.
- miss_ack  out  1  one-cycle pulse: fill_block valid, request finished.
- fill_block  out  256  block read from DDR; held until next capture.
- busy  out  1  high in every state except IDLE.
- err  out  1  sticky timeout flag; cleared only by rst.
- ram_en  out  1  DDR request enable.
- ram_write  out  1  1 = write, 0 = read.
- ram_addr  out  30  block-aligned word address; bits [2:0] always 0.
- data_to_ram  out  256  write data.
- ram_rdy  in  1  DDR operation complete; sampled only while ram_en is high.
- block_out  in  256  read data; valid in the cycle ram_rdy is high during a read.

Behaviour:
- Reset: state IDLE; ram_en=0, ram_write=0, ram_addr=0, data_to_ram=0, miss_ack=0, fill_block=0, busy=0, err=0, watchdog=0. Reset mid-operation abandons the transfer immediately, with ram_en low in the next cycle; no ack is issued.
- Acceptance: miss_req high in IDLE latches miss_addr, victim_addr, victim_block and miss_dirty. The block-aligned address is addr[29:3],3'b0. miss_req outside IDLE is ignored; it is not queued.
- States:
  - IDLE
  - WB_REQ
  - GAP
  - RD_REQ
  - DONE
- IDLE -> WB_REQ if dirty, else -> RD_REQ, on accept. ram_en rises in the cycle after miss_req.
- WB_REQ: ram_en=1, ram_write=1, ram_addr=victim block address, data_to_ram=victim_block. All outputs are held stable. When ram_rdy=1 -> GAP.
- GAP: ram_en=0 for exactly one cycle, then -> RD_REQ.
- RD_REQ: ram_en=1, ram_write=0, ram_addr=miss block address. When ram_rdy=1: fill_block<=block_out in that same edge, then -> DONE.
- DONE: ram_en=0, miss_ack=1 for one cycle, then -> IDLE. A new miss_req is accepted in the cycle after DONE at the earliest.
- Minimum latency from miss_req to miss_ack:
  - Clean miss with ram_rdy in the first request cycle: 3 cycles.
  - Dirty miss: 5 cycles.
- Watchdog:
  - Clears on entry to WB_REQ and RD_REQ; increments each cycle in those states while ram_rdy=0.
  - On reaching TIMEOUT_CYCLES: err<=1 and -> DONE. miss_ack still pulses; fill_block is unchanged from its last capture.
  - A timeout in WB_REQ skips the read.
  - ram_rdy and timeout in the same cycle: ram_rdy wins, no error.
- ram_rdy while ram_en=0 is ignored.
- ram_write is meaningful only while ram_en=1, and is driven 0 otherwise.
- Only one outstanding DDR operation at a time; no pipelining.

Test Plan:
- Clean miss: miss_addr=30'h0000_1234, dirty=0; ram_rdy after 10 cycles with block_out=256'hA5..A5.
  -> ram_en=1, ram_write=0, ram_addr=30'h0000_1230. Then fill_block=A5..A5, miss_ack pulses once, and busy falls the cycle after ack.
- Dirty miss: victim_addr=30'h0000_0047, miss_addr=30'h0000_0088.
  -> Write to 30'h0000_0040 with victim data. Then exactly one ram_en-low cycle. Then a read of 30'h0000_0088, then ack.
- Same-address repeat: two clean misses to 30'h10 back-to-back.
  -> ram_en deasserts between them and two distinct read operations occur.
- Timeout: TIMEOUT_CYCLES=16, ram_rdy never asserted.
  -> After 16 request cycles, err=1 and miss_ack pulses; err stays 1 through later successful misses until rst.
- Busy ignore / reset: miss_req pulses during RD_REQ are not served, and only one ack occurs. rst asserted in WB_REQ gives ram_en=0, busy=0, err=0 the next cycle, with no ack.
